// File: rtl/if_pkg.sv
// Shared types and constants for the IF-stage fetch queue.
package if_pkg;

   localparam int unsigned IF_EXC_W        = 19;
   localparam int unsigned IF_EXC_ADEL_BIT = 9;

   typedef struct packed {
      logic [31:0]         pc;
      logic [31:0]         instr;
      logic [IF_EXC_W-1:0] except;
   } if_entry_t;

   typedef enum logic [1:0] {
      FQ_IDLE,
      FQ_WAIT,
      FQ_DROP
   } fq_state_t;

endpackage

// File: rtl/if_fetch_queue_fq_ring.sv
// Ring buffer with two ordered write ports, one read port and an occupancy count.
module fq_ring #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 83
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear_i,
   input  logic                 wr0_en_i,
   input  logic [W-1:0]         wr0_data_i,
   input  logic                 wr1_en_i,
   input  logic [W-1:0]         wr1_data_i,
   input  logic                 rd_en_i,
   output logic [W-1:0]         rd_data_o,
   output logic [DEPTH:0]       count_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = DEPTH + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Port 1 is the second push of a pair and lands behind port 0's entry.
   always_comb begin
      wp_d  = wp_q + PW'(wr0_en_i) + PW'(wr1_en_i);
      rp_d  = rp_q + PW'(rd_en_i);
      cnt_d = cnt_q + CW'(wr0_en_i) + CW'(wr1_en_i) - CW'(rd_en_i);
      if (clear_i) begin
         wp_d  = '0;
         rp_d  = '0;
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (!clear_i && wr0_en_i) mem_q[wp_q] <= wr0_data_i;
         if (!clear_i && wr1_en_i) mem_q[wp_q + PW'(1)] <= wr1_data_i;
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
      end
   end

   assign rd_data_o = mem_q[rp_q];
   assign count_o   = cnt_q;

endmodule

// File: rtl/if_fetch_queue.sv
// IF-stage fetch queue: pairs accepted fetches with in-order I$ returns and
// buffers them for ID, discarding wrong-path returns after a flush.
module if_fetch_queue
   import if_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned EXC_W = IF_EXC_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pre_valid,
   input  logic [31:0]      pre_pc,
   input  logic [EXC_W-1:0] pre_except,
   input  logic             icache_data_ok,
   input  logic [31:0]      icache_rdata,
   input  logic             flush,
   input  logic             id_ready,
   output logic             fetch_allow,
   output logic             if_valid,
   output logic [31:0]      if_pc,
   output logic [31:0]      if_instr,
   output logic [EXC_W-1:0] if_except
);

   localparam int unsigned EW = 64 + EXC_W;
   localparam int unsigned SW = DEPTH + 3;

   fq_state_t        st_q, st_d;
   logic [31:0]      slot_pc_q, slot_pc_d;
   logic [EXC_W-1:0] slot_exc_q, slot_exc_d;

   logic             misalign, cache_fetch, local_fetch;
   logic [EXC_W-1:0] local_exc;
   logic [EW-1:0]    local_entry, wdata0, wdata1, rdata;
   logic             wr0, wr1, pop;
   logic [DEPTH:0]   count;
   logic [SW-1:0]    need;

   assign misalign    = pre_pc[1:0] != 2'b00;
   assign cache_fetch = pre_valid & (pre_except == '0) & ~misalign;
   assign local_fetch = pre_valid & ~cache_fetch;
   assign local_exc   = pre_except | (EXC_W'(misalign) << IF_EXC_ADEL_BIT);
   assign local_entry = {pre_pc, 32'h0, local_exc};

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q       <= FQ_IDLE;
         slot_pc_q  <= '0;
         slot_exc_q <= '0;
      end else begin
         st_q       <= st_d;
         slot_pc_q  <= slot_pc_d;
         slot_exc_q <= slot_exc_d;
      end
   end

   // A DROP whose return arrives behaves like IDLE for any fetch in that cycle.
   always_comb begin
      st_d       = st_q;
      slot_pc_d  = slot_pc_q;
      slot_exc_d = slot_exc_q;
      wr0        = 1'b0;
      wr1        = 1'b0;
      wdata0     = local_entry;
      wdata1     = local_entry;
      if (flush) begin
         st_d = (st_q != FQ_IDLE && !icache_data_ok) ? FQ_DROP : FQ_IDLE;
      end else begin
         unique case (st_q)
            FQ_IDLE, FQ_DROP: begin
               if (st_q == FQ_IDLE || icache_data_ok) begin
                  st_d = FQ_IDLE;
                  if (cache_fetch) begin
                     st_d       = FQ_WAIT;
                     slot_pc_d  = pre_pc;
                     slot_exc_d = pre_except;
                  end else if (local_fetch) begin
                     wr0 = 1'b1;
                  end
               end
            end
            FQ_WAIT: begin
               if (icache_data_ok) begin
                  wr0    = 1'b1;
                  wdata0 = {slot_pc_q, icache_rdata, slot_exc_q};
                  st_d   = FQ_IDLE;
                  if (cache_fetch) begin
                     st_d       = FQ_WAIT;
                     slot_pc_d  = pre_pc;
                     slot_exc_d = pre_except;
                  end else if (local_fetch) begin
                     wr1 = 1'b1;
                  end
               end
            end
            default: st_d = FQ_IDLE;
         endcase
      end
   end

   always_comb begin
      need        = SW'(count) + SW'(st_q == FQ_WAIT) + SW'(2);
      fetch_allow = (need <= SW'(DEPTH)) & ((st_q == FQ_IDLE) | icache_data_ok) & ~flush;
      if_valid    = count != '0;
      pop         = if_valid & id_ready;
      {if_pc, if_instr, if_except} = rdata;
   end

   fq_ring #(
      .DEPTH (DEPTH),
      .W     (EW)
   ) u_ring (
      .clk        (clk),
      .rst        (rst),
      .clear_i    (flush),
      .wr0_en_i   (wr0),
      .wr0_data_i (wdata0),
      .wr1_en_i   (wr1),
      .wr1_data_i (wdata1),
      .rd_en_i    (pop),
      .rd_data_o  (rdata),
      .count_o    (count)
   );

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: directed scenarios followed by
// random traffic, all checked against a queue-based reference model.
module tb_if_fetch_queue;
   import if_pkg::*;

   localparam int unsigned DEPTH = 4;

   logic                clk = 1'b0;
   logic                rst, pre_valid, icache_data_ok, flush, id_ready;
   logic [31:0]         pre_pc, icache_rdata;
   logic [IF_EXC_W-1:0] pre_except;
   logic                fetch_allow, if_valid;
   logic [31:0]         if_pc, if_instr;
   logic [IF_EXC_W-1:0] if_except;

   int total = 0;
   int bad   = 0;

   if_entry_t q[$];
   if_entry_t pend[$];
   bit        drop;

   always #5 clk = ~clk;

   if_fetch_queue #(.DEPTH(DEPTH), .EXC_W(IF_EXC_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .pre_valid      (pre_valid),
      .pre_pc         (pre_pc),
      .pre_except     (pre_except),
      .icache_data_ok (icache_data_ok),
      .icache_rdata   (icache_rdata),
      .flush          (flush),
      .id_ready       (id_ready),
      .fetch_allow    (fetch_allow),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_instr       (if_instr),
      .if_except      (if_except)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Room for everything queued or in flight plus two more, and no request
   // still outstanding unless it returns this cycle.
   function automatic bit exp_allow();
      bit outstanding;
      outstanding = (pend.size() != 0) || drop;
      return (q.size() + pend.size() + 2 <= DEPTH) && (!outstanding || icache_data_ok) && !flush;
   endfunction

   task automatic model_update();
      if_entry_t e;
      if (rst) begin
         q.delete(); pend.delete(); drop = 0;
         return;
      end
      if (flush) begin
         drop = ((pend.size() != 0) || drop) && !icache_data_ok;
         q.delete(); pend.delete();
         return;
      end
      if (q.size() != 0 && id_ready) void'(q.pop_front());
      if (icache_data_ok) begin
         if (drop) drop = 0;
         else if (pend.size() != 0) begin
            e = pend.pop_front();
            e.instr = icache_rdata;
            q.push_back(e);
         end
      end
      if (pre_valid) begin
         e.pc = pre_pc; e.instr = '0; e.except = pre_except;
         if (pre_except == '0 && pre_pc[1:0] == 2'b00) pend.push_back(e);
         else begin
            if (pre_pc[1:0] != 2'b00) e.except[IF_EXC_ADEL_BIT] = 1'b1;
            q.push_back(e);
         end
      end
   endtask

   task automatic cycle();
      #1;
      if (pre_valid) check("protocol_allow", 64'(fetch_allow), 64'd1);
      check("fetch_allow", 64'(fetch_allow), 64'(exp_allow()));
      check("if_valid", 64'(if_valid), 64'(q.size() != 0));
      if (q.size() != 0) begin
         check("if_pc", 64'(if_pc), 64'(q[0].pc));
         check("if_instr", 64'(if_instr), 64'(q[0].instr));
         check("if_except", 64'(if_except), 64'(q[0].except));
      end
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic drive(input bit pv, input logic [31:0] pc, input logic [IF_EXC_W-1:0] exc,
                        input bit dok, input logic [31:0] rd, input bit fl, input bit rdy);
      pre_valid = pv; pre_pc = pc; pre_except = exc;
      icache_data_ok = dok; icache_rdata = rd; flush = fl; id_ready = rdy;
   endtask

   task automatic random_step(input int pv_pct, input bit rdy, input int fl_pct);
      logic [31:0] r;
      rst = 1'b0;
      icache_data_ok = ((pend.size() != 0) || drop) && ($urandom_range(0, 99) < 60);
      icache_rdata = $urandom;
      flush = $urandom_range(0, 99) < fl_pct;
      id_ready = rdy;
      r = $urandom;
      pre_pc = r & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) pre_pc[1:0] = 2'($urandom_range(1, 3));
      case ($urandom_range(0, 15))
         0, 1:    pre_except = IF_EXC_W'(1) << 8;
         2:       pre_except = IF_EXC_W'($urandom);
         default: pre_except = '0;
      endcase
      pre_valid = exp_allow() && ($urandom_range(0, 99) < pv_pct);
      cycle();
   endtask

   task automatic check_reset_outputs();
      #1;
      check("rst_if_valid", 64'(if_valid), 64'd0);
      check("rst_if_pc", 64'(if_pc), 64'd0);
      check("rst_if_instr", 64'(if_instr), 64'd0);
      check("rst_if_except", 64'(if_except), 64'd0);
      check("rst_fetch_allow", 64'(fetch_allow), 64'd1);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      drive(0, '0, '0, 0, '0, 0, 1);
      drop = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check_reset_outputs();

      // Streaming with one-cycle returns
      drive(1, 32'hBFC0_0000, '0, 0, '0, 0, 1);           cycle();
      drive(1, 32'hBFC0_0004, '0, 1, 32'h2408_0001, 0, 1); cycle();
      drive(1, 32'hBFC0_0008, '0, 1, 32'h2408_0002, 0, 1); cycle();
      drive(0, '0, '0, 1, 32'h2408_0003, 0, 1);            cycle();
      drive(0, '0, '0, 0, '0, 0, 1);                       repeat (3) cycle();

      // Back-pressure, then drain
      repeat (12) random_step(100, 1'b0, 0);
      repeat (8)  random_step(0, 1'b1, 0);

      // Flush while a request is in flight
      drive(1, 32'h8000_0010, '0, 0, '0, 0, 1);            cycle();
      drive(0, '0, '0, 0, '0, 1, 1);                       cycle();
      drive(0, '0, '0, 1, 32'hDEAD_BEEF, 0, 1);            cycle();
      check("flush_no_deadbeef", 64'(if_valid && if_instr == 32'hDEAD_BEEF), 64'd0);
      drive(1, 32'h8000_0100, '0, 0, '0, 0, 1);            cycle();
      drive(0, '0, '0, 1, 32'h1234_5678, 0, 1);            cycle();
      drive(0, '0, '0, 0, '0, 0, 1);                       repeat (2) cycle();

      // Misaligned local fetch behind a returning cache fetch
      drive(1, 32'h0000_1000, '0, 0, '0, 0, 1);            cycle();
      drive(1, 32'h0000_1006, '0, 1, 32'h1111_2222, 0, 1); cycle();
      drive(0, '0, '0, 0, '0, 0, 1);                       repeat (3) cycle();

      // TLB refill fetch bypasses the cache
      drive(1, 32'h0040_0000, IF_EXC_W'(1) << 8, 0, '0, 0, 1); cycle();
      drive(0, '0, '0, 0, '0, 0, 1);                       repeat (2) cycle();

      // Reset with entries queued and a request outstanding
      drive(1, 32'h0000_3000, '0, 0, '0, 0, 0);            cycle();
      drive(1, 32'h0000_3004, '0, 1, 32'hAAAA_0001, 0, 0); cycle();
      drive(0, '0, '0, 1, 32'hAAAA_0002, 0, 0);            cycle();
      drive(1, 32'h0000_3008, '0, 0, '0, 0, 0);            cycle();
      check("pre_reset_valid", 64'(if_valid), 64'd1);
      rst = 1'b1;
      drive(0, '0, '0, 0, '0, 0, 0);                       cycle();
      rst = 1'b0;
      drive(0, '0, '0, 1, 32'hCAFE_F00D, 0, 1);
      check_reset_outputs();
      drive(0, '0, '0, 0, '0, 0, 1);                       cycle();
      check("late_data_ignored", 64'(if_valid), 64'd0);

      // Random traffic
      for (int i = 0; i < 2000; i++)
         random_step(60, ($urandom_range(0, 3) != 0), 5);
      drive(0, '0, '0, 0, '0, 0, 1);
      repeat (6) random_step(0, 1'b1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
